// File: rtl/npu_csr_master.sv
// npu_csr_master: queues host CSR commands and issues them one at a time on the
// NPU CSR bus. Each bus transaction has a bounded wait for csr_ready, and the
// result is returned to the host through a valid/ready response channel.
module npu_csr_master #(
    parameter int          CMD_DEPTH      = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        csr_valid,
    output logic        csr_write,
    output logic [7:0]  csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic        csr_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] txn_count,
    output logic [7:0]  timeout_count
);

    localparam int         AW       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nxt;

    // Command queue storage: {write, addr, wdata}
    logic [40:0]   mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty, full;

    // Holding registers for the command currently being serviced
    logic          hold_vld;
    logic          hold_write;
    logic [7:0]    hold_addr;
    logic [31:0]   hold_wdata;

    logic [7:0]    bus_cnt;
    logic          bus_timeout;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    // The head is only taken while IDLE with an empty holding stage, so the
    // command sits in holding for one IDLE cycle before the bus phase begins.
    assign pop       = (state == IDLE) && !hold_vld && !empty;

    assign bus_timeout = (state == BUS) && !csr_ready && (bus_cnt == TO_LAST);

    // Queue storage write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // Queue pointers and occupancy; simultaneous push and pop keep count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Holding stage: load the queue head, release it when the bus phase starts
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld   <= 1'b0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (pop) begin
            hold_vld <= 1'b1;
            {hold_write, hold_addr, hold_wdata} <= mem[rd_ptr];
        end else if (state == IDLE && hold_vld) begin
            hold_vld <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hold_vld) state_nxt = BUS;
            BUS:     if (csr_ready || bus_cnt == TO_LAST) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus-phase cycle counter, response capture and transaction statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_cnt       <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            txn_count     <= '0;
            timeout_count <= '0;
        end else begin
            if (state == IDLE)     bus_cnt <= '0;
            else if (state == BUS) bus_cnt <= bus_cnt + 1'b1;

            // A ready on the final allowed cycle still wins over the timeout
            if (state == BUS && csr_ready) begin
                rsp_data_q <= hold_write ? 32'h0 : csr_rdata;
                rsp_err_q  <= 1'b0;
            end else if (bus_timeout) begin
                rsp_data_q <= hold_write ? 32'h0 : ERR_RDATA;
                rsp_err_q  <= 1'b1;
                if (timeout_count != 8'hFF) timeout_count <= timeout_count + 1'b1;
            end

            if (state == RESP && rsp_ready) txn_count <= txn_count + 1'b1;
        end
    end

    // Bus and response outputs are forced to zero outside their active phase
    assign csr_valid = (state == BUS);
    assign csr_write = csr_valid && hold_write;
    assign csr_addr  = csr_valid ? hold_addr  : 8'h0;
    assign csr_wdata = csr_valid ? hold_wdata : 32'h0;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rsp_data_q : 32'h0;
    assign rsp_err   = rsp_valid && rsp_err_q;

    assign busy = !empty || hold_vld || (state != IDLE);

endmodule
